// File: rtl/pmem_arbiter.sv
// pmem_arbiter: merges the I-cache and D-cache 256-bit line ports onto one physical
// memory port with one transaction in flight. Define ARB_ROUND_ROBIN_EN to alternate tie grants.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake: a client holds read/write high with stable address/wdata until its
  // *_resp pulse; the grant is held from acceptance in IDLE until pmem_resp.
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic                  i_pmem_read,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_d = 1 when D was the client most recently granted.
  logic last_grant_d;
  assign pick_d = d_req & (~i_req | ~last_grant_d);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state <= SERVE_D;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b1;
`endif
          end else if (i_req) begin
            state <= SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs follow the granted client; held at zero while reset is asserted so the
  // reset cycle itself is quiet even if a transaction was in flight.
  always_comb begin
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (!rst) begin
      case (state)
        SERVE_I: begin
          pmem_address = i_pmem_address;
          pmem_read    = i_pmem_read;
          i_pmem_resp  = pmem_resp;
        end
        SERVE_D: begin
          pmem_address = d_pmem_address;
          pmem_read    = d_pmem_read;
          pmem_write   = d_pmem_write;
          pmem_wdata   = d_pmem_wdata;
          d_pmem_resp  = pmem_resp;
        end
        default: ;
      endcase
    end
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized two-client
// traffic against a line-level memory reference; honours ARB_ROUND_ROBIN_EN for tie order.
`timescale 1ns/1ps
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_read;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic [AW-1:0] d_pmem_address;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic [AW-1:0] pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int vectors = 0;
  int miscompares = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // ---------------- memory model and line reference ----------------
  bit            mem_auto = 1'b1;
  bit            mem_rand_lat = 1'b0;
  int            mem_lat = 2;
  logic [LW-1:0] phys_mem [logic [AW-1:0]];
  logic [LW-1:0] ref_mem  [logic [AW-1:0]];

  function automatic logic [LW-1:0] line_default(input logic [AW-1:0] a);
    return {8{a ^ 32'h5a5a_0000}};
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : line_default(a);
  endfunction

  initial begin : mem_model
    bit            busy;
    bit            wr;
    int            cnt;
    logic [AW-1:0] a;
    logic [LW-1:0] wd;
    busy = 1'b0; wr = 1'b0; cnt = 0; a = '0; wd = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto) begin
        busy = 1'b0;
        continue;
      end
      if (rst) begin
        busy = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0; busy = 1'b0;
      end else if (busy) begin
        vectors++;
        if (pmem_address !== a || pmem_write !== wr || pmem_read !== !wr ||
            (wr && pmem_wdata !== wd)) begin
          miscompares++;
          $display("FAIL mem_stable: addr=%h rd=%b wr=%b, required addr=%h wr=%b",
                   pmem_address, pmem_read, pmem_write, a, wr);
        end
        cnt--;
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          if (wr) phys_mem[a] = wd;
          else pmem_rdata = phys_mem.exists(a) ? phys_mem[a] : line_default(a);
        end
      end else if (pmem_read || pmem_write) begin
        busy = 1'b1; a = pmem_address; wr = pmem_write; wd = pmem_wdata;
        cnt = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      end
    end
  end

  // Routing invariants checked every cycle, and resp pulse counting.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      vectors++;
      if (i_pmem_rdata !== pmem_rdata || d_pmem_rdata !== pmem_rdata) begin
        miscompares++;
        $display("FAIL rdata_route: i=%h d=%h, required %h", i_pmem_rdata, d_pmem_rdata, pmem_rdata);
      end
      vectors++;
      if ((i_pmem_resp && !i_pmem_read) || (d_pmem_resp && !(d_pmem_read || d_pmem_write)) ||
          (i_pmem_resp && d_pmem_resp)) begin
        miscompares++;
        $display("FAIL resp_route: i_resp=%b d_resp=%b i_rd=%b d_rd=%b d_wr=%b, required resp only to requester",
                 i_pmem_resp, d_pmem_resp, i_pmem_read, d_pmem_read, d_pmem_write);
      end
      if (i_pmem_resp) i_pulses++;
      if (d_pmem_resp) d_pulses++;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    i_pmem_address = '0; i_pmem_read = 1'b0;
    d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    tick();
    tick();
    vectors++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_pmem_resp, d_pmem_resp} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h, required all 0", pmem_read, pmem_write, pmem_address);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    logic [LW-1:0] a5;
    int ip0, dp0, seen;
    a5 = {32{8'hA5}};
    phys_mem[32'h100] = a5;
    ref_mem[32'h100] = a5;
    mem_lat = 3;
    ip0 = i_pulses; dp0 = d_pulses; seen = -1;
    i_pmem_address = 32'h100; i_pmem_read = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      vectors++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h100) begin
        miscompares++;
        $display("FAIL i_read_fwd: cyc=%0d rd=%b addr=%h, required rd=1 addr=100", c, pmem_read, pmem_address);
      end
      if (i_pmem_resp) begin
        seen = c;
        break;
      end
      tick();
    end
    vectors++;
    if (seen !== 4) begin
      miscompares++;
      $display("FAIL i_read_latency: resp at cycle %0d, required 4", seen);
    end
    vectors++;
    if (i_pmem_rdata !== a5) begin
      miscompares++;
      $display("FAIL i_read_data: got %h, required %h", i_pmem_rdata, a5);
    end
    i_pmem_read = 1'b0;
    tick();
    vectors++;
    if (pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL i_read_idle: rd=%b, required 0", pmem_read);
    end
    tick();
    vectors++;
    if (i_pulses - ip0 !== 1 || d_pulses - dp0 !== 0) begin
      miscompares++;
      $display("FAIL i_read_pulses: i=%0d d=%0d, required i=1 d=0", i_pulses - ip0, d_pulses - dp0);
    end
  endtask

  task automatic test_d_write();
    logic [LW-1:0] wd;
    int dp0, seen;
    wd = {16{16'h1234}};
    mem_lat = 2;
    dp0 = d_pulses; seen = -1;
    d_pmem_address = 32'h200; d_pmem_wdata = wd; d_pmem_write = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      vectors++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== wd || pmem_address !== 32'h200) begin
        miscompares++;
        $display("FAIL d_write_fwd: cyc=%0d wr=%b addr=%h wdata=%h, required wr=1 addr=200 wdata=%h",
                 c, pmem_write, pmem_address, pmem_wdata, wd);
      end
      if (d_pmem_resp) begin
        seen = c;
        break;
      end
      tick();
    end
    vectors++;
    if (seen !== 3) begin
      miscompares++;
      $display("FAIL d_write_latency: resp at cycle %0d, required 3", seen);
    end
    ref_mem[32'h200] = wd;
    d_pmem_write = 1'b0;
    tick();
    vectors++;
    if (pmem_write !== 1'b0 || pmem_address !== '0) begin
      miscompares++;
      $display("FAIL d_write_idle: wr=%b addr=%h, required 0", pmem_write, pmem_address);
    end
    vectors++;
    if (d_pulses - dp0 !== 1) begin
      miscompares++;
      $display("FAIL d_write_pulses: %0d, required 1", d_pulses - dp0);
    end
  endtask

  task automatic test_tie();
    int nwin, last, w, exp_w;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_lat = 2;
    nwin = 0; last = 0;  // 0 = I, 1 = D; reset leaves I as last served
    i_pmem_address = 32'h300; d_pmem_address = 32'h400;
    i_pmem_read = 1'b1; d_pmem_read = 1'b1;
    for (int c = 0; c < 100 && nwin < 3; c++) begin
      tick();
      if (i_pmem_resp || d_pmem_resp) begin
        w = d_pmem_resp ? 1 : 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_w = (last == 1) ? 0 : 1;
`else
        exp_w = 1;
`endif
        vectors++;
        if (w !== exp_w) begin
          miscompares++;
          $display("FAIL tie_order: tie %0d served %s, required %s", nwin, w ? "D" : "I", exp_w ? "D" : "I");
        end
        vectors++;
        if (pmem_address !== (w ? 32'h400 : 32'h300)) begin
          miscompares++;
          $display("FAIL tie_addr: addr=%h for client %s", pmem_address, w ? "D" : "I");
        end
        last = w;
        nwin++;
      end
    end
    vectors++;
    if (nwin !== 3) begin
      miscompares++;
      $display("FAIL tie_timeout: %0d grants seen, required 3", nwin);
    end
    if (last == 1) d_pmem_read = 1'b0; else i_pmem_read = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (i_pmem_resp) begin i_pmem_read = 1'b0; break; end
      if (d_pmem_resp) begin d_pmem_read = 1'b0; break; end
    end
    vectors++;
    if (i_pmem_read || d_pmem_read) begin
      miscompares++;
      $display("FAIL tie_drain: loser never served");
      i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    end
    tick();
  endtask

  task automatic test_mid_grant();
    bit got;
    mem_lat = 4;
    got = 1'b0;
    d_pmem_address = 32'h400; d_pmem_read = 1'b1;
    tick();
    i_pmem_address = 32'h300; i_pmem_read = 1'b1;
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if (pmem_address !== 32'h400 || i_pmem_resp !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_hold: addr=%h i_resp=%b, required addr=400 i_resp=0", pmem_address, i_pmem_resp);
      end
      if (d_pmem_resp) begin got = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL mid_timeout: no d_pmem_resp, required one");
    end
    d_pmem_read = 1'b0;
    tick();
    vectors++;
    if (pmem_read !== 1'b0 || pmem_address !== '0) begin
      miscompares++;
      $display("FAIL mid_turnaround: rd=%b addr=%h, required idle", pmem_read, pmem_address);
    end
    tick();
    vectors++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h300) begin
      miscompares++;
      $display("FAIL mid_i_grant: rd=%b addr=%h, required rd=1 addr=300", pmem_read, pmem_address);
    end
    for (int c = 0; c < 20; c++) begin
      if (i_pmem_resp) break;
      tick();
    end
    i_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_lat = 8;
    d_pmem_address = 32'h500; d_pmem_wdata = {8{32'hdead_beef}}; d_pmem_write = 1'b1;
    tick();
    tick();
    rst = 1'b1; d_pmem_write = 1'b0;
    #1;
    vectors++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_pmem_resp, d_pmem_resp} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_cycle: rd=%b wr=%b addr=%h, required all 0", pmem_read, pmem_write, pmem_address);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_pmem_resp, d_pmem_resp} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_after: rd=%b wr=%b addr=%h, required all 0", pmem_read, pmem_write, pmem_address);
    end
    mem_auto = 1'b0;
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = {8{$urandom()}};
    #1;
    vectors++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_resp: i_resp=%b d_resp=%b, required 0", i_pmem_resp, d_pmem_resp);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    vectors++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_idle: rd=%b wr=%b, required 0", pmem_read, pmem_write);
    end
    mem_auto = 1'b1;
    tick();
  endtask

  task automatic test_random();
    mem_rand_lat = 1'b1;
    fork
      begin : i_client
        logic [AW-1:0] a;
        bit got;
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          a = 32'h1000 + 32'h20 * $urandom_range(0, 7);
          i_pmem_address = a; i_pmem_read = 1'b1;
          got = 1'b0;
          for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (i_pmem_resp) got = 1'b1;
          end
          vectors++;
          if (!got) begin
            miscompares++;
            $display("FAIL rand_i_timeout: addr=%h", a);
          end else if (i_pmem_rdata !== ref_line(a)) begin
            miscompares++;
            $display("FAIL rand_i_data: addr=%h got %h, required %h", a, i_pmem_rdata, ref_line(a));
          end
          i_pmem_read = 1'b0;
          tick();
        end
      end
      begin : d_client
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        bit got, wr;
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          a = 32'h1000 + 32'h20 * $urandom_range(0, 7);
          wr = $urandom_range(0, 1) == 1;
          for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom();
          d_pmem_address = a; d_pmem_wdata = wd;
          d_pmem_write = wr; d_pmem_read = !wr;
          got = 1'b0;
          for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (d_pmem_resp) got = 1'b1;
          end
          vectors++;
          if (!got) begin
            miscompares++;
            $display("FAIL rand_d_timeout: addr=%h wr=%b", a, wr);
          end else if (wr) begin
            ref_mem[a] = wd;
          end else if (d_pmem_rdata !== ref_line(a)) begin
            miscompares++;
            $display("FAIL rand_d_data: addr=%h got %h, required %h", a, d_pmem_rdata, ref_line(a));
          end
          d_pmem_read = 1'b0; d_pmem_write = 1'b0;
          tick();
        end
      end
    join
    mem_rand_lat = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_i_read();
    test_d_write();
    test_tie();
    test_mid_grant();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
Downstream of the instruction and data caches. Merges their two 256-bit cacheline memory ports onto the single physical memory port.
Only one transaction is outstanding at a time. The arbiter holds the grant from acceptance until pmem_resp, then routes the response to the owning cache only.

Parameters:
ADDR_WIDTH, 32, width of line addresses on all ports
LINE_WIDTH, 256, cacheline data width on all ports

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
i_pmem_address  input  ADDR_WIDTH  I-cache line address
i_pmem_read  input  1  I-cache read request (I-cache never writes)
i_pmem_rdata  output  LINE_WIDTH  line data to I-cache
i_pmem_resp  output  1  I-cache completion pulse
d_pmem_address  input  ADDR_WIDTH  D-cache line address
d_pmem_read  input  1  D-cache read request
d_pmem_write  input  1  D-cache write-back request
d_pmem_wdata  input  LINE_WIDTH  D-cache write-back line
d_pmem_rdata  output  LINE_WIDTH  line data to D-cache
d_pmem_resp  output  1  D-cache completion pulse
pmem_address  output  ADDR_WIDTH  physical memory address
pmem_read  output  1  physical memory read
pmem_write  output  1  physical memory write
pmem_wdata  output  LINE_WIDTH  physical memory write data
pmem_rdata  input  LINE_WIDTH  physical memory read data
pmem_resp  input  1  physical memory completion, one-cycle pulse

Behaviour:
- Client protocol: a request is held asserted with stable address/wdata until the matching *_resp pulse. The client deasserts no earlier than the cycle after resp. d_pmem_read and d_pmem_write are never asserted together.
- FSM states: IDLE, SERVE_I, SERVE_D. State is registered; all outputs are combinational from state and the granted client's inputs.
- IDLE:
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Only D requesting -> SERVE_D. Only I requesting -> SERVE_I. Neither -> stay in IDLE.
  - Both requesting -> SERVE_D (fixed D priority; see optional feature).
- SERVE_I:
  - pmem_address=i_pmem_address, pmem_read=i_pmem_read, pmem_write=0.
  - i_pmem_resp=pmem_resp. On pmem_resp -> IDLE.
- SERVE_D:
  - pmem_address=d_pmem_address, pmem_read=d_pmem_read, pmem_write=d_pmem_write, pmem_wdata=d_pmem_wdata.
  - d_pmem_resp=pmem_resp. On pmem_resp -> IDLE.
- Response routing: i_pmem_rdata and d_pmem_rdata both equal pmem_rdata at all times. The *_resp of a client that is not granted is always 0.
- Latency:
  - A request seen in IDLE at edge n is driven to memory during cycle n+1.
  - After pmem_resp, one mandatory IDLE cycle before the next grant (turnaround).
  - Back-to-back service therefore costs memory latency + 2 cycles per line.
- Grant is never revoked before pmem_resp. If the granted client illegally drops its request, the arbiter keeps forwarding its (now low) signals and waits.
- pmem_resp arriving while in IDLE is ignored; no client resp is generated.
- Reset: state <- IDLE. On the reset cycle and the cycle after, all outputs are 0.
- Reset mid-transaction abandons the grant. Memory is reset by the same rst.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a last_grant register (reset value I, so D wins the first tie) records the client last served. On a simultaneous request in IDLE, the grant goes to the client that is not last_grant. last_grant updates on entry to SERVE_I or SERVE_D.
- Undefined: no last_grant register; ties always go to D.

Test Plan:
- After rst, i_pmem_read=1 with address 0x100; memory returns resp 3 cycles later with rdata=0xA5..A5. Required: pmem_read=1 and pmem_address=0x100 from cycle 1; i_pmem_resp pulses once with data 0xA5..A5; d_pmem_resp stays 0.
- d_pmem_write=1, address 0x200, wdata=0x1234..; resp after 2 cycles. Required: pmem_write=1 and pmem_wdata=0x1234.. throughout; d_pmem_resp pulses once; return to IDLE.
- I and D request in the same cycle (I 0x300, D 0x400), ties repeated 3 times.
  - Without macro: D served first every time.
  - With macro: D, then I, then D order across the ties.
- D is granted and waiting; I raises a request mid-transaction. Required: pmem_address stays 0x400 until resp; i_pmem_resp=0; I is granted after exactly one IDLE cycle.
- rst asserted during SERVE_D before resp. Required: next cycle all outputs 0, state IDLE; a stray pmem_resp one cycle later produces no client resp.
